alu_seq_ctrl: RTL

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

---
 rtl/alu_pkg.sv | 56 +++++
 rtl/alu_seq_ctrl_if.sv | 36 +++
 rtl/alu_iter_cnt.sv | 25 ++
 rtl/alu_seq_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencing controller: state encoding,
// opcodes and radix-4 Booth decode.
package alu_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_ARITH,
    S_SHIFT,
    S_CORR,
    S_OUT_LO,
    S_OUT_HI,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [2:0] BTH_Z0  = 3'b000;
  localparam logic [2:0] BTH_P1A = 3'b001;
  localparam logic [2:0] BTH_P1B = 3'b010;
  localparam logic [2:0] BTH_P2  = 3'b011;
  localparam logic [2:0] BTH_M2  = 3'b100;
  localparam logic [2:0] BTH_M1A = 3'b101;
  localparam logic [2:0] BTH_M1B = 3'b110;
  localparam logic [2:0] BTH_Z1  = 3'b111;

  typedef struct packed {
    logic add;
    logic sub;
    logic x2;
  } booth_t;

  function automatic booth_t booth_dec(input logic [2:0] q);
    booth_t b;
    b = '0;
    case (q)
      BTH_P1A, BTH_P1B: b.add = 1'b1;
      BTH_P2: begin
        b.add = 1'b1;
        b.x2  = 1'b1;
      end
      BTH_M2: begin
        b.sub = 1'b1;
        b.x2  = 1'b1;
      end
      BTH_M1A, BTH_M1B: b.sub = 1'b1;
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Handshake and strobe bundle between the ALU datapath/requester
// (master) and the sequencing controller (slave).
interface alu_seq_ctrl_if;
  logic       bgn;
  logic [1:0] opcode;
  logic [2:0] qbits;
  logic       a_sign;
  logic       div_zero;
  logic       c_ld;
  logic       c_add;
  logic       c_sub;
  logic       c_x2;
  logic       c_shr2;
  logic       c_shl;
  logic       c_qset;
  logic       c_corr;
  logic       c_out_lo;
  logic       c_out_hi;
  logic       busy;
  logic       stop;
  logic       err;

  modport master (
    output bgn, opcode, qbits, a_sign, div_zero,
    input  c_ld, c_add, c_sub, c_x2, c_shr2, c_shl,
    input  c_qset, c_corr, c_out_lo, c_out_hi,
    input  busy, stop, err
  );

  modport slave (
    input  bgn, opcode, qbits, a_sign, div_zero,
    output c_ld, c_add, c_sub, c_x2, c_shr2, c_shl,
    output c_qset, c_corr, c_out_lo, c_out_hi,
    output busy, stop, err
  );
endinterface

// File: rtl/alu_iter_cnt.sv
// Iteration counter: clear, increment, terminal compare.
// Saturates at the terminal value so it never wraps.
module alu_iter_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_term
);

  logic [CNT_W-1:0] r_cnt;

  assign o_term = (r_cnt == i_last);

  always_ff @(posedge clk) begin
    if (rst || i_clr)
      r_cnt <= '0;
    else if (i_inc && !o_term)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for ADD/SUB/Booth-MUL/non-restoring DIV.
// Optional divide-by-zero short cut: define ALU_DIV0_DETECT_EN.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  alu_seq_ctrl_if.slave  bus
);

  state_t           r_state;
  state_t           w_nxt;
  logic [1:0]       r_op;
  booth_t           r_bop;
  logic             r_dz;
  logic             w_dz;
  logic             w_term;
  logic             w_clr;
  logic             w_inc;
  logic [CNT_W-1:0] w_last;
  logic             w_mul;
  logic             w_div;

`ifdef ALU_DIV0_DETECT_EN
  assign w_dz = bus.div_zero;
`else
  logic w_unused_dz;
  assign w_unused_dz = bus.div_zero;
  assign w_dz = 1'b0;
`endif

  assign w_mul  = (r_op == OP_MUL);
  assign w_div  = (r_op == OP_DIV);
  assign w_last = w_mul ? CNT_W'(WIDTH/2 - 1)
                        : CNT_W'(WIDTH - 1);
  assign w_clr  = (r_state == S_LOAD);
  assign w_inc  = (r_state == S_SHIFT && w_mul) ||
                  (r_state == S_EVAL && w_div);

  alu_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .i_last (w_last),
    .o_term (w_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
      r_bop   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_LOAD) begin
        r_op <= bus.opcode;
        r_dz <= w_dz && (bus.opcode == OP_DIV);
      end
      if (r_state == S_EVAL && w_mul)
        r_bop <= booth_dec(bus.qbits);
    end
  end

  // Booth digit is registered in EVAL so ARITH strobes stay state-decoded.
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (bus.bgn) w_nxt = S_LOAD;
      S_LOAD:
        unique case (bus.opcode)
          OP_MUL:  w_nxt = S_EVAL;
          OP_DIV:  w_nxt = w_dz ? S_DONE : S_SHIFT;
          default: w_nxt = S_ARITH;
        endcase
      S_EVAL:
        if (w_mul)
          w_nxt = (booth_dec(bus.qbits) != '0) ? S_ARITH
                                               : S_SHIFT;
        else if (w_term)
          w_nxt = bus.a_sign ? S_CORR : S_OUT_LO;
        else
          w_nxt = S_SHIFT;
      S_ARITH:
        if (w_mul)      w_nxt = S_SHIFT;
        else if (w_div) w_nxt = S_EVAL;
        else            w_nxt = S_OUT_LO;
      S_SHIFT:
        if (w_mul) w_nxt = w_term ? S_OUT_LO : S_EVAL;
        else       w_nxt = S_ARITH;
      S_CORR:   w_nxt = S_OUT_LO;
      S_OUT_LO: w_nxt = r_op[1] ? S_OUT_HI : S_DONE;
      S_OUT_HI: w_nxt = S_DONE;
      S_DONE:   w_nxt = S_IDLE;
      default:  w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.c_ld     = 1'b0;
    bus.c_add    = 1'b0;
    bus.c_sub    = 1'b0;
    bus.c_x2     = 1'b0;
    bus.c_shr2   = 1'b0;
    bus.c_shl    = 1'b0;
    bus.c_qset   = 1'b0;
    bus.c_corr   = 1'b0;
    bus.c_out_lo = 1'b0;
    bus.c_out_hi = 1'b0;
    bus.stop     = 1'b0;
    bus.err      = 1'b0;
    bus.busy     = (r_state != S_IDLE);
    unique case (r_state)
      S_LOAD: bus.c_ld = 1'b1;
      S_EVAL: bus.c_qset = w_div;
      S_ARITH:
        if (w_mul) begin
          bus.c_add = r_bop.add;
          bus.c_sub = r_bop.sub;
          bus.c_x2  = r_bop.x2;
        end else if (w_div) begin
          bus.c_add = bus.a_sign;
          bus.c_sub = !bus.a_sign;
        end else begin
          bus.c_add = (r_op == OP_ADD);
          bus.c_sub = (r_op == OP_SUB);
        end
      S_SHIFT: begin
        bus.c_shr2 = w_mul;
        bus.c_shl  = !w_mul;
      end
      S_CORR: begin
        bus.c_add  = 1'b1;
        bus.c_corr = 1'b1;
      end
      S_OUT_LO: bus.c_out_lo = 1'b1;
      S_OUT_HI: bus.c_out_hi = 1'b1;
      S_DONE: begin
        bus.stop = 1'b1;
        bus.err  = r_dz;
      end
      default: ;
    endcase
  end

endmodule
